// File: rtl/nibble_add_sched.sv
// Round-robin scheduler that time-shares one external 4-bit adder between NREQ
// requesters, running each W-bit add one nibble per cycle, LSB nibble first.
module nibble_add_sched #(
  parameter  int NREQ = 2,
  parameter  int NIB  = 4,
  localparam int W    = 4 * NIB,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ-1:0]   cin,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      sum,
  output logic              cout,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_ci,
  input  logic [3:0]        add_s,
  input  logic              add_co
);

  localparam int CW = $clog2(NIB + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [IDW-1:0]      rr;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      id_lat;
  logic                found;
  logic [2*NREQ-1:0]   req_rot;
  logic [W-1:0]        a_sel, b_sel;
  logic                cin_sel;
  logic [W-1:0]        a_lat, b_lat;
  logic                cin_lat;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        sum_int;
  logic [W-1:0]        sum_nxt;

  // Arbitration: rotate the request vector so the rr pointer sits at bit 0,
  // then take the first set bit.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // otherwise the tool infers a latch to hold the unassigned case.
    found   = 1'b0;
    win     = '0;
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    req_rot = {req, req} >> rr;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        win   = IDW'((int'(rr) + j) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel   = a_in[i*W +: W];
        b_sel   = b_in[i*W +: W];
        cin_sel = cin[i];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst_n && state == IDLE && found) gnt[win] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Shared adder drive and the partial sum with this cycle's nibble merged in.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_ci  = 1'b0;
    sum_nxt = sum_int;
    if (state == RUN) begin
      add_ci = (cnt == '0) ? cin_lat : carry;
      for (int j = 0; j < NIB; j++) begin
        if (cnt == CW'(j)) begin
          add_a            = a_lat[4*j +: 4];
          add_b            = b_lat[4*j +: 4];
          sum_nxt[4*j +: 4] = add_s;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr      <= '0;
      id_lat  <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      cin_lat <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_int <= '0;
      done    <= 1'b0;
      done_id <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            a_lat   <= a_sel;
            b_lat   <= b_sel;
            cin_lat <= cin_sel;
            id_lat  <= win;
            cnt     <= '0;
            rr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_int <= sum_nxt;
          carry   <= add_co;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            sum     <= sum_nxt;
            cout    <= add_co;
            done_id <= id_lat;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
